wb_timeout_splitter: RTL

Parametrised successor to the team's Wishbone bus splitter. It fans one Wishbone master out to NUM_PERIPHERALS slaves through registered address-window decode. A per-transaction watchdog terminates hung slaves with an error, and accesses to unmapped or disabled slots also return an error. Error status (last faulting address, saturating count, timeout pulse) is exported so the PIC and firmware can diagnose bus faults.

---
 rtl/wb_split_pkg.sv | 19 +
 rtl/wb_timeout_splitter_if.sv | 27 ++
 rtl/wb_bus_watchdog.sv | 37 +++
 rtl/wb_timeout_splitter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wb_split_pkg.sv
// Shared types for the Wishbone timeout splitter: transaction FSM states and
// the slot decode validity rule.
package wb_split_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RESP_ACK,
    ST_RESP_ERR
  } state_e;

  // A slot is addressable only if it exists and firmware has enabled it.
  function automatic logic slot_valid(input int unsigned idx,
                                      input int unsigned num_slots,
                                      input logic        slot_en);
    return (idx < num_slots) && slot_en;
  endfunction

endpackage

// File: rtl/wb_timeout_splitter_if.sv
// Upstream (master-facing) Wishbone port of the splitter. Signal names carry the
// direction as seen from the splitter.
interface wb_timeout_splitter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic [ADDR_WIDTH-1:0] m_wb_adr_i;
  logic [DATA_WIDTH-1:0] m_wb_dat_i;
  logic [SEL_WIDTH-1:0]  m_wb_sel_i;
  logic                  m_wb_we_i;
  logic                  m_wb_cyc_i;
  logic                  m_wb_stb_i;
  logic [DATA_WIDTH-1:0] m_wb_dat_o;
  logic                  m_wb_ack_o;
  logic                  m_wb_err_o;

  modport master (
    output m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_cyc_i, m_wb_stb_i,
    input  m_wb_dat_o, m_wb_ack_o, m_wb_err_o
  );

  modport slave (
    input  m_wb_adr_i, m_wb_dat_i, m_wb_sel_i, m_wb_we_i, m_wb_cyc_i, m_wb_stb_i,
    output m_wb_dat_o, m_wb_ack_o, m_wb_err_o
  );
endinterface

// File: rtl/wb_bus_watchdog.sv
// Per-transaction watchdog: counts strobed cycles without a response and flags
// expiry in the TIMEOUT_CYCLES-th such cycle.
module wb_bus_watchdog
  import wb_split_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/wb_timeout_splitter.sv
// One Wishbone master fanned out to NUM_PERIPHERALS slaves with registered
// address-window decode, a hung-slave watchdog and exported error status.
module wb_timeout_splitter
  import wb_split_pkg::*;
#(
  parameter int NUM_PERIPHERALS  = 27,
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int SEL_WIDTH        = 4,
  parameter int ADDR_SEL_LOW_BIT = 16,
  parameter int ADDR_SEL_WIDTH   = 5,
  parameter int TIMEOUT_CYCLES   = 255,
  parameter int ERR_CNT_WIDTH    = 8
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_n,
  wb_timeout_splitter_if.slave                  m_bus,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
  output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
  output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
  output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
  output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
  input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
  input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i,
  input  logic [NUM_PERIPHERALS-1:0]            periph_en_i,
  input  logic                                  err_clr_i,
  output logic                                  timeout_o,
  output logic [ADDR_WIDTH-1:0]                 err_adr_o,
  output logic [ERR_CNT_WIDTH-1:0]              err_cnt_o
);
  localparam int SLOTS = 2 ** ADDR_SEL_WIDTH;

  state_e                     state_q, state_d;
  logic [NUM_PERIPHERALS-1:0] slot_q, slot_d;
  logic [ADDR_WIDTH-1:0]      adr_q, adr_d, err_adr_q, err_adr_d;
  logic [DATA_WIDTH-1:0]      wdat_q, wdat_d, rdat_q, rdat_d, rdat_sel;
  logic [SEL_WIDTH-1:0]       sel_q, sel_d;
  logic                       we_q, we_d, timeout_q, timeout_d;
  logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

  logic [ADDR_SEL_WIDTH-1:0]  req_idx;
  logic [SLOTS-1:0]           en_ext;
  logic                       req_valid, ack_hit, err_hit, wd_en, wd_expire, enter_err;
  logic [DATA_WIDTH-1:0]      rdat_masked [NUM_PERIPHERALS];

  assign req_idx = m_bus.m_wb_adr_i[ADDR_SEL_LOW_BIT +: ADDR_SEL_WIDTH];

  // Unpopulated slots read as disabled so one lookup covers both decode faults.
  always_comb begin
    en_ext                      = '0;
    en_ext[NUM_PERIPHERALS-1:0] = periph_en_i;
  end

  assign req_valid = slot_valid(32'(req_idx), 32'(NUM_PERIPHERALS), en_ext[req_idx]);
  assign ack_hit   = |(s_wb_ack_i & slot_q);
  assign err_hit   = |(s_wb_err_i & slot_q);
  assign wd_en     = (state_q == ST_ACTIVE) && !ack_hit && !err_hit;

  generate
    for (genvar gi = 0; gi < NUM_PERIPHERALS; gi++) begin : g_fanout
      assign s_wb_adr_o[gi*ADDR_WIDTH +: ADDR_WIDTH] = adr_q;
      assign s_wb_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = wdat_q;
      assign s_wb_sel_o[gi*SEL_WIDTH +: SEL_WIDTH]   = sel_q;
      assign s_wb_we_o[gi]                           = we_q;
      assign rdat_masked[gi] = s_wb_dat_i[gi*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{slot_q[gi]}};
    end
  endgenerate

  always_comb begin
    rdat_sel = '0;
    for (int i = 0; i < NUM_PERIPHERALS; i++) begin
      rdat_sel = rdat_sel | rdat_masked[i];
    end
  end

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_n),
    .clr_i   (state_q != ST_ACTIVE),
    .en_i    (wd_en),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    adr_d     = adr_q;
    wdat_d    = wdat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rdat_d    = rdat_q;
    timeout_d = 1'b0;
    enter_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m_bus.m_wb_cyc_i && m_bus.m_wb_stb_i) begin
          adr_d  = m_bus.m_wb_adr_i;
          wdat_d = m_bus.m_wb_dat_i;
          sel_d  = m_bus.m_wb_sel_i;
          we_d   = m_bus.m_wb_we_i;
          if (req_valid) begin
            state_d = ST_ACTIVE;
            slot_d  = NUM_PERIPHERALS'(1) << req_idx;
          end else begin
            state_d   = ST_RESP_ERR;
            rdat_d    = '0;
            enter_err = 1'b1;
          end
        end
      end
      ST_ACTIVE: begin
        // Abort wins: the master has walked away, so nobody is owed a response.
        if (!m_bus.m_wb_cyc_i) begin
          state_d = ST_IDLE;
          slot_d  = '0;
        end else if (err_hit || wd_expire) begin
          state_d   = ST_RESP_ERR;
          slot_d    = '0;
          rdat_d    = '0;
          enter_err = 1'b1;
          timeout_d = wd_expire;
        end else if (ack_hit) begin
          state_d = ST_RESP_ACK;
          slot_d  = '0;
          rdat_d  = rdat_sel;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    err_cnt_d = err_cnt_q;
    err_adr_d = err_adr_q;
    if (err_clr_i) begin
      err_cnt_d = '0;
      err_adr_d = '0;
    end else if (enter_err) begin
      err_adr_d = adr_d;
      err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= ST_IDLE;
      slot_q    <= '0;
      adr_q     <= '0;
      wdat_q    <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rdat_q    <= '0;
      timeout_q <= 1'b0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      adr_q     <= adr_d;
      wdat_q    <= wdat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rdat_q    <= rdat_d;
      timeout_q <= timeout_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_bus.m_wb_ack_o = (state_q == ST_RESP_ACK);
  assign m_bus.m_wb_err_o = (state_q == ST_RESP_ERR);
  assign m_bus.m_wb_dat_o = rdat_q;
  assign s_wb_cyc_o       = slot_q;
  assign s_wb_stb_o       = slot_q;
  assign timeout_o        = timeout_q;
  assign err_adr_o        = err_adr_q;
  assign err_cnt_o        = err_cnt_q;
endmodule
